pcie_cpl_tx: RTL and testbench

//  Completion transmitter for the PCIe endpoint core's VC0 transmit TLP interface (16-bit).

---
 rtl/pcie_cpl_tx.sv | 159 +++++++++++++++
 tb/tb_pcie_cpl_tx.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pcie_cpl_tx.sv
// Completion transmitter: turns one decoded request into a 3DW-header CplD/Cpl TLP
// on the 16-bit VC0 transmit interface, gated on completion credits.
module pcie_cpl_tx #(
   parameter bit CREDIT_CHECK = 1'b1
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic [15:0] cfg_id,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_with_data,
   input  logic [2:0]  req_status,
   input  logic [15:0] req_rid,
   input  logic [7:0]  req_tag,
   input  logic [6:0]  req_laddr,
   input  logic [31:0] req_data,
   output logic        tx_req_vc0,
   input  logic        tx_rdy_vc0,
   output logic        tx_st_vc0,
   output logic        tx_end_vc0,
   output logic [15:0] tx_data_vc0,
   output logic        tx_nlfy_vc0,
   input  logic [8:0]  tx_ca_cplh_vc0,
   input  logic [12:0] tx_ca_cpld_vc0,
   output logic        cpl_done
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_CREDIT,
      S_REQ,
      S_SEND
   } state_e;

   state_e      state_q;
   logic [2:0]  idx_q;
   logic        with_data_q;
   logic [2:0]  status_q;
   logic [15:0] cid_q;
   logic [15:0] rid_q;
   logic [7:0]  tag_q;
   logic [6:0]  laddr_q;
   logic [31:0] data_q;
   logic        tx_req_q;
   logic        tx_st_q;
   logic        tx_end_q;
   logic [15:0] tx_data_q;
   logic        cpl_done_q;

   logic [2:0]       last_idx;
   logic [2:0]       idx_d;
   logic             credit_ok;
   logic [7:0][15:0] words;

   assign last_idx = with_data_q ? 3'd7 : 3'd5;
   assign idx_d    = idx_q + 3'd1;

   // Header/payload words of the captured request, upper half of each DW first.
   always_comb begin
      words[0] = with_data_q ? 16'h4A00 : 16'h0A00;
      words[1] = with_data_q ? 16'h0001 : 16'h0000;
      words[2] = cid_q;
      words[3] = {status_q, 1'b0, 12'd4};
      words[4] = rid_q;
      words[5] = {tag_q, 1'b0, laddr_q};
      words[6] = data_q[31:16];
      words[7] = data_q[15:0];
   end

   always_comb begin
      credit_ok = 1'b1;
      if (CREDIT_CHECK) begin
         credit_ok = (tx_ca_cplh_vc0 != 9'd0) &&
                     (!with_data_q || (tx_ca_cpld_vc0 != 13'd0));
      end
   end

   // NOTE: all state here uses non-blocking assignments so every register sees
   // pre-edge values; the captured request is reset too, so a packet aborted by
   // rstn leaves nothing stale behind.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q     <= S_IDLE;
         idx_q       <= 3'd0;
         with_data_q <= 1'b0;
         status_q    <= 3'd0;
         cid_q       <= 16'd0;
         rid_q       <= 16'd0;
         tag_q       <= 8'd0;
         laddr_q     <= 7'd0;
         data_q      <= 32'd0;
         tx_req_q    <= 1'b0;
         tx_st_q     <= 1'b0;
         tx_end_q    <= 1'b0;
         tx_data_q   <= 16'd0;
         cpl_done_q  <= 1'b0;
      end else begin
         cpl_done_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (req_valid) begin
                  with_data_q <= req_with_data;
                  status_q    <= req_with_data ? 3'b000 : req_status;
                  cid_q       <= cfg_id;
                  rid_q       <= req_rid;
                  tag_q       <= req_tag;
                  laddr_q     <= req_laddr;
                  data_q      <= req_data;
                  state_q     <= S_CREDIT;
               end
            end
            S_CREDIT: begin
               if (credit_ok) begin
                  tx_req_q <= 1'b1;
                  state_q  <= S_REQ;
               end
            end
            S_REQ: begin
               if (tx_rdy_vc0) begin
                  tx_req_q  <= 1'b0;
                  idx_q     <= 3'd0;
                  tx_st_q   <= 1'b1;
                  tx_end_q  <= 1'b0;
                  tx_data_q <= words[0];
                  state_q   <= S_SEND;
               end
            end
            S_SEND: begin
               // A low tx_rdy simply leaves every output register untouched.
               if (tx_rdy_vc0) begin
                  if (idx_q == last_idx) begin
                     idx_q      <= 3'd0;
                     tx_st_q    <= 1'b0;
                     tx_end_q   <= 1'b0;
                     tx_data_q  <= 16'd0;
                     cpl_done_q <= 1'b1;
                     state_q    <= S_IDLE;
                  end else begin
                     idx_q     <= idx_d;
                     tx_st_q   <= 1'b0;
                     tx_end_q  <= (idx_d == last_idx);
                     tx_data_q <= words[idx_d];
                  end
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign req_ready   = (state_q == S_IDLE);
   assign tx_req_vc0  = tx_req_q;
   assign tx_st_vc0   = tx_st_q;
   assign tx_end_vc0  = tx_end_q;
   assign tx_data_vc0 = tx_data_q;
   assign tx_nlfy_vc0 = 1'b0;
   assign cpl_done    = cpl_done_q;

endmodule

// File: tb/tb_pcie_cpl_tx.sv
// Self-checking bench for pcie_cpl_tx: directed cases plus randomized traffic,
// with every transmitted word compared against a TLP model built from the request.
module tb_pcie_cpl_tx;

   logic        clk = 1'b0;
   logic        rstn;
   logic [15:0] cfg_id;
   logic        req_valid;
   logic        req_ready;
   logic        req_with_data;
   logic [2:0]  req_status;
   logic [15:0] req_rid;
   logic [7:0]  req_tag;
   logic [6:0]  req_laddr;
   logic [31:0] req_data;
   logic        tx_req_vc0;
   logic        tx_rdy_vc0;
   logic        tx_st_vc0;
   logic        tx_end_vc0;
   logic [15:0] tx_data_vc0;
   logic        tx_nlfy_vc0;
   logic [8:0]  tx_ca_cplh_vc0;
   logic [12:0] tx_ca_cpld_vc0;
   logic        cpl_done;

   logic        nc_req_valid;
   logic        nc_req_ready;
   logic        nc_tx_req;
   logic        nc_tx_rdy;
   logic        nc_tx_st;
   logic        nc_tx_end;
   logic [15:0] nc_tx_data;
   logic        nc_tx_nlfy;
   logic        nc_cpl_done;

   pcie_cpl_tx dut (
      .clk(clk), .rstn(rstn), .cfg_id(cfg_id),
      .req_valid(req_valid), .req_ready(req_ready), .req_with_data(req_with_data),
      .req_status(req_status), .req_rid(req_rid), .req_tag(req_tag),
      .req_laddr(req_laddr), .req_data(req_data),
      .tx_req_vc0(tx_req_vc0), .tx_rdy_vc0(tx_rdy_vc0), .tx_st_vc0(tx_st_vc0),
      .tx_end_vc0(tx_end_vc0), .tx_data_vc0(tx_data_vc0), .tx_nlfy_vc0(tx_nlfy_vc0),
      .tx_ca_cplh_vc0(tx_ca_cplh_vc0), .tx_ca_cpld_vc0(tx_ca_cpld_vc0),
      .cpl_done(cpl_done)
   );

   pcie_cpl_tx #(.CREDIT_CHECK(1'b0)) dut_nc (
      .clk(clk), .rstn(rstn), .cfg_id(cfg_id),
      .req_valid(nc_req_valid), .req_ready(nc_req_ready), .req_with_data(req_with_data),
      .req_status(req_status), .req_rid(req_rid), .req_tag(req_tag),
      .req_laddr(req_laddr), .req_data(req_data),
      .tx_req_vc0(nc_tx_req), .tx_rdy_vc0(nc_tx_rdy), .tx_st_vc0(nc_tx_st),
      .tx_end_vc0(nc_tx_end), .tx_data_vc0(nc_tx_data), .tx_nlfy_vc0(nc_tx_nlfy),
      .tx_ca_cplh_vc0(tx_ca_cplh_vc0), .tx_ca_cpld_vc0(tx_ca_cpld_vc0),
      .cpl_done(nc_cpl_done)
   );

   always #4 clk = ~clk;

   typedef struct packed {
      logic [7:0][15:0] w;
      logic [3:0]       n;
   } pkt_t;

   int   n_tests = 0;
   int   n_fail  = 0;
   int   n_done  = 0;
   int   exp_done = 0;
   bit   rand_done = 1'b0;
   pkt_t exp_q[$];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Reference TLP: header DWs assembled from the field rules, then split into halves.
   function automatic pkt_t build(input bit wd, input logic [2:0] st, input logic [15:0] cid,
                                  input logic [15:0] rid, input logic [7:0] tag,
                                  input logic [6:0] la, input logic [31:0] d);
      pkt_t        p;
      logic [31:0] dw[4];
      logic [2:0]  s;
      s     = wd ? 3'b000 : st;
      dw[0] = wd ? 32'h4A00_0001 : 32'h0A00_0000;
      dw[1] = {cid, s, 1'b0, 12'd4};
      dw[2] = {rid, tag, 1'b0, la};
      dw[3] = d;
      p     = '0;
      for (int i = 0; i < 4; i++) begin
         p.w[2*i]   = dw[i][31:16];
         p.w[2*i+1] = dw[i][15:0];
      end
      p.n = wd ? 4'd8 : 4'd6;
      return p;
   endfunction

   task automatic monitor();
      pkt_t        cur;
      int          idx = 0;
      bit          in_pkt = 1'b0;
      bit          stalled = 1'b0;
      bit          done_due = 1'b0;
      logic [15:0] held = '0;
      cur = '0;
      forever begin
         @(negedge clk);
         if (!rstn) begin
            in_pkt = 1'b0; stalled = 1'b0; done_due = 1'b0;
            exp_q.delete();
         end else begin
            if (done_due || cpl_done) begin
               check("cpl_done", 32'(cpl_done), 32'(done_due));
               check("ready_on_done", 32'(req_ready), 1);
               if (cpl_done) n_done++;
            end
            done_due = 1'b0;
            if (tx_nlfy_vc0) check("nlfy", 32'(tx_nlfy_vc0), 0);
            if (tx_st_vc0 && !in_pkt) begin
               if (exp_q.size() == 0) check("stray_start", 32'(tx_st_vc0), 0);
               else begin
                  cur = exp_q.pop_front();
                  in_pkt = 1'b1; idx = 0; stalled = 1'b0;
               end
            end
            if (in_pkt) begin
               check("ready_in_pkt", 32'(req_ready), 0);
               check("txreq_in_pkt", 32'(tx_req_vc0), 0);
               if (stalled) check("stall_hold", 32'(tx_data_vc0), 32'(held));
               check($sformatf("word%0d", idx), 32'(tx_data_vc0), 32'(cur.w[idx]));
               check("st_flag", 32'(tx_st_vc0), 32'(idx == 0));
               check("end_flag", 32'(tx_end_vc0), 32'(idx == int'(cur.n) - 1));
               if (tx_rdy_vc0) begin
                  stalled = 1'b0;
                  if (idx == int'(cur.n) - 1) begin
                     in_pkt = 1'b0; done_due = 1'b1;
                  end else idx++;
               end else begin
                  stalled = 1'b1; held = tx_data_vc0;
               end
            end else if (tx_end_vc0) check("stray_end", 32'(tx_end_vc0), 0);
            if (req_valid && req_ready)
               exp_q.push_back(build(req_with_data, req_status, cfg_id, req_rid,
                                     req_tag, req_laddr, req_data));
         end
      end
   endtask

   task automatic set_req(input bit wd, input logic [2:0] st, input logic [15:0] rid,
                          input logic [7:0] tag, input logic [6:0] la, input logic [31:0] d);
      req_with_data = wd; req_status = st; req_rid = rid;
      req_tag = tag; req_laddr = la; req_data = d;
   endtask

   // Holds req_valid until accepted; returns at posedge+1 of the cycle after acceptance.
   task automatic send_req(input bit wd, input logic [2:0] st, input logic [15:0] rid,
                           input logic [7:0] tag, input logic [6:0] la, input logic [31:0] d);
      int c = 0;
      set_req(wd, st, rid, tag, la, d);
      req_valid = 1'b1;
      @(negedge clk);
      while (!req_ready && c < 200) begin @(negedge clk); c++; end
      check("accept_timeout", 32'(c < 200), 1);
      @(posedge clk); #1;
      req_valid = 1'b0;
      exp_done++;
   endtask

   task automatic wait_pkts(input int target, input int budget);
      int c = 0;
      while (n_done < target && c < budget) begin @(posedge clk); c++; end
      check("pkt_timeout", n_done, target);
      #1;
   endtask

   task automatic wait_start();
      int c = 0;
      @(negedge clk);
      while (!tx_st_vc0 && c < 100) begin @(negedge clk); c++; end
      check("start_timeout", 32'(c < 100), 1);
   endtask

   task automatic check_latency(input string tag);
      @(negedge clk);
      check({tag, "_req_early"}, 32'(tx_req_vc0), 0);
      @(negedge clk);
      check({tag, "_req_rise"}, 32'(tx_req_vc0), 1);
   endtask

   initial begin
      int cnt;
      rstn = 1'b0; cfg_id = 16'h0100; req_valid = 1'b0; tx_rdy_vc0 = 1'b1;
      set_req(1'b0, 3'b000, 16'h0000, 8'h00, 7'h00, 32'h0);
      tx_ca_cplh_vc0 = 9'd4; tx_ca_cpld_vc0 = 13'd8;
      nc_req_valid = 1'b0; nc_tx_rdy = 1'b1;
      fork monitor(); join_none
      #13;
      check("rst_ready", 32'(req_ready), 1);
      check("rst_txreq", 32'(tx_req_vc0), 0);
      check("rst_st", 32'(tx_st_vc0), 0);
      check("rst_end", 32'(tx_end_vc0), 0);
      check("rst_data", 32'(tx_data_vc0), 0);
      check("rst_done", 32'(cpl_done), 0);
      check("rst_nlfy", 32'(tx_nlfy_vc0), 0);
      @(posedge clk); #1 rstn = 1'b1;

      // CplD and UR Cpl reference packets
      send_req(1'b1, 3'b000, 16'h0000, 8'h05, 7'h10, 32'hDEAD_BEEF);
      check_latency("cpld");
      wait_pkts(exp_done, 50);
      send_req(1'b0, 3'b001, 16'h0000, 8'h05, 7'h10, 32'h1357_9BDF);
      check_latency("ur");
      wait_pkts(exp_done, 50);

      // Header credit starvation
      tx_ca_cplh_vc0 = 9'd0;
      send_req(1'b0, 3'b001, 16'h0000, 8'h05, 7'h10, 32'h0);
      cnt = 0;
      repeat (20) begin @(negedge clk); if (tx_req_vc0) cnt++; end
      check("cplh0_hold", cnt, 0);
      @(posedge clk); #1 tx_ca_cplh_vc0 = 9'd4;
      check_latency("cplh");
      wait_pkts(exp_done, 50);

      // Data credit starvation: Cpl passes, CplD held
      tx_ca_cpld_vc0 = 13'd0;
      send_req(1'b0, 3'b100, 16'h0000, 8'h06, 7'h11, 32'h0);
      check_latency("cpl_nodata_credit");
      wait_pkts(exp_done, 50);
      send_req(1'b1, 3'b001, 16'h0000, 8'h07, 7'h12, 32'hCAFE_F00D);
      cnt = 0;
      repeat (20) begin @(negedge clk); if (tx_req_vc0) cnt++; end
      check("cpld0_hold", cnt, 0);
      @(posedge clk); #1 tx_ca_cpld_vc0 = 13'd8;
      check_latency("cpld");
      wait_pkts(exp_done, 50);

      // Credit checking disabled: no hold with zero credits
      tx_ca_cplh_vc0 = 9'd0; tx_ca_cpld_vc0 = 13'd0;
      set_req(1'b1, 3'b000, 16'h0000, 8'h08, 7'h13, 32'h0);
      check("nc_ready", 32'(nc_req_ready), 1);
      nc_req_valid = 1'b1;
      @(posedge clk); #1 nc_req_valid = 1'b0;
      @(negedge clk); check("nc_req_early", 32'(nc_tx_req), 0);
      @(negedge clk); check("nc_req_rise", 32'(nc_tx_req), 1);
      cnt = 0;
      while (!nc_cpl_done && cnt < 30) begin @(negedge clk); cnt++; end
      check("nc_done", 32'(nc_cpl_done), 1);
      @(posedge clk); #1;
      tx_ca_cplh_vc0 = 9'd4; tx_ca_cpld_vc0 = 13'd8;

      // Stall on word 3
      send_req(1'b1, 3'b000, 16'h0000, 8'h05, 7'h10, 32'hDEAD_BEEF);
      wait_start();
      @(posedge clk); @(posedge clk); #1 tx_rdy_vc0 = 1'b0;
      cnt = 0;
      repeat (3) begin
         @(negedge clk);
         if (tx_data_vc0 == 16'h0100) cnt++;
         @(posedge clk);
      end
      #1 tx_rdy_vc0 = 1'b1;
      check("stall_word3", cnt, 3);
      wait_pkts(exp_done, 50);

      // Reset while word 5 is presented
      send_req(1'b1, 3'b000, 16'h1234, 8'h05, 7'h10, 32'hDEAD_BEEF);
      wait_start();
      repeat (4) @(posedge clk);
      #2 check("pre_rst_word5", 32'(tx_data_vc0), 32'h1234);
      rstn = 1'b0;
      #1;
      check("arst_txreq", 32'(tx_req_vc0), 0);
      check("arst_st", 32'(tx_st_vc0), 0);
      check("arst_end", 32'(tx_end_vc0), 0);
      check("arst_data", 32'(tx_data_vc0), 0);
      exp_done--;
      @(posedge clk); @(posedge clk); #2 rstn = 1'b1;
      #1 check("post_rst_ready", 32'(req_ready), 1);
      send_req(1'b1, 3'b000, 16'h0000, 8'h09, 7'h14, 32'h0BAD_C0DE);
      wait_pkts(exp_done, 50);

      // Back-to-back with req_valid held high
      set_req(1'b1, 3'b000, 16'hA1A1, 8'h11, 7'h21, 32'h1111_2222);
      req_valid = 1'b1;
      @(negedge clk);
      @(posedge clk); #1;
      exp_done++;
      set_req(1'b0, 3'b100, 16'hB2B2, 8'h22, 7'h7F, 32'h3333_4444);
      cnt = 0;
      @(negedge clk);
      while (!req_ready && cnt < 200) begin @(negedge clk); cnt++; end
      check("b2b_accept_on_done", 32'(cpl_done), 1);
      @(posedge clk); #1 req_valid = 1'b0;
      exp_done++;
      wait_pkts(exp_done, 100);

      // Randomized traffic with random back-pressure and post-accept input churn
      fork
         begin
            for (int k = 0; k < 40; k++) begin
               logic [2:0] st;
               case ($urandom_range(0, 2))
                  0:       st = 3'b000;
                  1:       st = 3'b001;
                  default: st = 3'b100;
               endcase
               repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
               cfg_id         = 16'($urandom);
               tx_ca_cplh_vc0 = 9'($urandom_range(1, 511));
               tx_ca_cpld_vc0 = 13'($urandom_range(1, 8191));
               send_req(1'($urandom), st, 16'($urandom), 8'($urandom),
                        7'($urandom), $urandom);
               cfg_id = 16'($urandom);
               set_req(1'($urandom), 3'($urandom), 16'($urandom), 8'($urandom),
                       7'($urandom), $urandom);
            end
            wait_pkts(exp_done, 2000);
            rand_done = 1'b1;
         end
         begin
            while (!rand_done) begin
               @(posedge clk); #1;
               tx_rdy_vc0 = 1'($urandom);
            end
            tx_rdy_vc0 = 1'b1;
         end
      join

      check("final_done_count", n_done, exp_done);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
